// File: rtl/vae_pkg.sv
// rtl/vae_pkg.sv - shared types, constants and helpers for the VAE latent dot-product engine
package vae_pkg;

  localparam int BEATS  = 8;
  localparam int LANES  = 4;
  localparam int FRAC   = 8;
  localparam int ACC_W  = 40;
  localparam int PROD_W = 32;
  localparam int SUM_W  = PROD_W + 3;

  typedef logic signed [15:0] q88_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic q88_t lane(input logic [63:0] word, input int k);
    return q88_t'(word[16*k +: 16]);
  endfunction

  function automatic q88_t sat16(input logic signed [ACC_W-1:0] v);
    if (v > ACC_W'(32767))
      return q88_t'(16'h7FFF);
    else if (v < ACC_W'(-32768))
      return q88_t'(16'h8000);
    else
      return q88_t'(v[15:0]);
  endfunction

endpackage

// File: rtl/vae_latent_dot_dot8.sv
// rtl/vae_latent_dot_dot8.sv - dot8_q88: eight Q8.8 multipliers and a registered adder tree
module dot8_q88
  import vae_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [63:0]             x_lo,
  input  logic [63:0]             x_hi,
  input  logic [63:0]             w_lo,
  input  logic [63:0]             w_hi,
  output logic                    out_valid,
  output logic signed [SUM_W-1:0] sum
);

  logic signed [PROD_W-1:0] prod_q [8];
  logic                     prod_valid;
  logic signed [SUM_W-1:0]  tree;

  always_comb begin
    tree = '0;
    for (int i = 0; i < 8; i++)
      tree = tree + SUM_W'(prod_q[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_valid <= 1'b0;
      out_valid  <= 1'b0;
      sum        <= '0;
      for (int i = 0; i < 8; i++)
        prod_q[i] <= '0;
    end else if (en) begin
      prod_valid <= in_valid;
      out_valid  <= prod_valid;
      sum        <= tree;
      for (int i = 0; i < 8; i++)
        prod_q[i] <= PROD_W'(lane(i < LANES ? x_lo : x_hi, i % LANES)) *
                     PROD_W'(lane(i < LANES ? w_lo : w_hi, i % LANES));
    end
  end

endmodule

// File: rtl/vae_latent_dot.sv
// rtl/vae_latent_dot.sv - run FSM, beat counter, accumulator and Q8.8 finaliser
module vae_latent_dot
  import vae_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic        read_en,
  input  logic        op_mode,
  input  logic [15:0] bias,
  input  logic [63:0] DMA_channel_0,
  input  logic [63:0] DMA_channel_1,
  input  logic [63:0] DMA_channel_2,
  input  logic [63:0] DMA_channel_3,
  output logic        done,
  output logic [15:0] result
);

  state_t                  state, state_n;
  logic [3:0]              beat_cnt;
  logic [1:0]              drain_cnt;
  logic signed [ACC_W-1:0] acc;
  q88_t                    bias_q;
  logic                    mode_q;
  logic                    arm_ok;
  logic                    capture;
  logic                    sum_valid;
  logic signed [SUM_W-1:0] beat_sum;
  logic signed [ACC_W-1:0] scaled;
  q88_t                    sat_val;
  q88_t                    final_val;

  // clr flushes the pipeline too, so an aborted run leaves nothing in flight
  dot8_q88 u_dot (
    .clk       (clk),
    .rst       (rst_n | clr),
    .en        (en),
    .in_valid  (capture),
    .x_lo      (DMA_channel_0),
    .x_hi      (DMA_channel_1),
    .w_lo      (DMA_channel_2),
    .w_hi      (DMA_channel_3),
    .out_valid (sum_valid),
    .sum       (beat_sum)
  );

  always_comb begin
    state_n = state;
    capture = 1'b0;
    case (state)
      ST_IDLE:   if (en && read_en && arm_ok) state_n = ST_ARM;
      ST_ARM:    if (en) state_n = ST_STREAM;
      ST_STREAM: begin
        capture = en & read_en;
        if (capture && beat_cnt == 4'(BEATS - 1)) state_n = ST_DRAIN;
      end
      ST_DRAIN:  if (en && drain_cnt == 2'd3) state_n = ST_DONE;
      ST_DONE:   if (en) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    scaled    = (acc >>> FRAC) + ACC_W'(bias_q);
    sat_val   = sat16(scaled);
    final_val = mode_q ? (sat_val >>> 1) : sat_val;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      acc       <= '0;
      bias_q    <= '0;
      mode_q    <= 1'b0;
      arm_ok    <= 1'b1;
      done      <= 1'b0;
      result    <= '0;
    end else if (clr) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      acc       <= '0;
      arm_ok    <= 1'b1;
      done      <= 1'b0;
    end else if (en) begin
      state <= state_n;
      done  <= 1'b0;
      if (state == ST_IDLE && state_n == ST_ARM) begin
        bias_q <= q88_t'(bias);
        mode_q <= op_mode;
        arm_ok <= 1'b0;
      end
      if (capture) beat_cnt <= beat_cnt + 4'd1;
      if (state == ST_DRAIN) drain_cnt <= drain_cnt + 2'd1;
      if (sum_valid) acc <= acc + ACC_W'(beat_sum);
      if (state == ST_DRAIN && state_n == ST_DONE) begin
        done   <= 1'b1;
        result <= final_val;
      end
    end
  end

endmodule

// File: tb/tb_vae_latent_dot.sv
// tb/tb_vae_latent_dot.sv - directed self-checking bench for vae_latent_dot
module tb_vae_latent_dot;

  logic        clk = 1'b0;
  logic        rst_n, en, clr, read_en, op_mode;
  logic [15:0] bias;
  logic [63:0] ch0, ch1, ch2, ch3;
  logic        done;
  logic [15:0] result;

  int errors = 0;
  int checks = 0;
  int n = 0;
  int dones;
  logic got;

  localparam logic [15:0] JUNK = 16'h7FFF;

  vae_latent_dot dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .read_en(read_en),
    .op_mode(op_mode), .bias(bias),
    .DMA_channel_0(ch0), .DMA_channel_1(ch1),
    .DMA_channel_2(ch2), .DMA_channel_3(ch3),
    .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [15:0] xv, input logic [15:0] wv);
    ch0 = {4{xv}}; ch1 = {4{xv}};
    ch2 = {4{wv}}; ch3 = {4{wv}};
  endtask

  // clr pulse, arm cycle (bias/op_mode latched), then the ARM cycle; n=0 at its negedge
  task automatic start_run(input logic [15:0] bv, input logic m);
    @(negedge clk); clr = 1'b1; en = 1'b1; read_en = 1'b0;
    @(negedge clk); clr = 1'b0; read_en = 1'b1; bias = bv; op_mode = m; set_data(JUNK, JUNK);
    @(negedge clk); n = 0; bias = 16'h1234; op_mode = ~m; set_data(JUNK, JUNK);
  endtask

  task automatic beat(input logic [15:0] xv, input logic [15:0] wv);
    @(negedge clk); n++; en = 1'b1; read_en = 1'b1; set_data(xv, wv);
  endtask

  task automatic stall(input int k, input bit use_en);
    for (int i = 0; i < k; i++) begin
      @(negedge clk); n++;
      set_data(JUNK, JUNK);
      if (use_en) begin en = 1'b0; read_en = 1'b1; end
      else        begin en = 1'b1; read_en = 1'b0; end
    end
  endtask

  task automatic wait_done(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); n++; en = 1'b1; read_en = 1'b0;
      if (done) begin seen = 1'b1; break; end
    end
  endtask

  task automatic run_full(input string tag, input logic [15:0] xv, input logic [15:0] wv,
                          input logic [15:0] bv, input logic m, input int stall_at,
                          input bit use_en, input logic [15:0] exp_res, input int exp_lat);
    logic seen;
    start_run(bv, m);
    for (int b = 0; b < 8; b++) begin
      if (b == stall_at) stall(3, use_en);
      beat(xv, wv);
    end
    wait_done(30, seen);
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_res"}, 32'(result), 32'(exp_res));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; en = 1'b0; clr = 1'b0; read_en = 1'b0; op_mode = 1'b0;
    bias = 16'h0; set_data(16'h0, 16'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'h0);

    run_full("unity",   16'h0100, 16'h0100, 16'h0000, 1'b0, 99, 1'b0, 16'h4000, 13);
    run_full("bias",    16'h0100, 16'h0080, 16'hF580, 1'b0, 99, 1'b0, 16'h1580, 13);
    run_full("logstd",  16'h0100, 16'h0080, 16'hF580, 1'b1, 99, 1'b0, 16'h0AC0, 13);
    run_full("sat_neg", 16'h8000, 16'h7FFF, 16'h0000, 1'b0, 99, 1'b0, 16'h8000, 13);
    run_full("sat_pos", 16'h7FFF, 16'h7FFF, 16'h7000, 1'b0, 99, 1'b0, 16'h7FFF, 13);
    run_full("rd_stall", 16'h0100, 16'h0100, 16'h0000, 1'b0, 4, 1'b0, 16'h4000, 16);
    run_full("en_stall", 16'h0100, 16'h0080, 16'hF580, 1'b0, 4, 1'b1, 16'h1580, 16);

    // read_en held high after done must not start a new run without clr
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk); en = 1'b1; read_en = 1'b1; set_data(16'h0100, 16'h0100);
      if (done) dones++;
    end
    check("no_rearm_done", 32'(dones), 32'd0);
    check("no_rearm_res", 32'(result), 32'h1580);

    // clr after five beats aborts the run
    start_run(16'h0000, 1'b0);
    for (int b = 0; b < 5; b++) beat(16'h0100, 16'h0100);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    wait_done(20, got);
    check("clr_abort_done", 32'(got), 32'd0);
    check("clr_abort_res", 32'(result), 32'h1580);
    run_full("after_clr", 16'h0100, 16'h0080, 16'hF580, 1'b1, 99, 1'b0, 16'h0AC0, 13);

    // reset mid-run
    start_run(16'h0000, 1'b0);
    for (int b = 0; b < 3; b++) beat(16'h0100, 16'h0100);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    check("rst_mid_res", 32'(result), 32'h0);
    wait_done(20, got);
    check("rst_mid_done", 32'(got), 32'd0);
    check("rst_mid_res_hold", 32'(result), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
